// File: rtl/scan_display_scheduler.sv
// Multiplexed display scanner: one-hot COM select with a blanking gap before each digit,
// fed from a double-buffered digit store that swaps only at frame boundaries.
module scan_display_scheduler #(
  parameter int DIGITS = 4,
  parameter int DW     = 4,
  parameter int DWELL  = 2048,
  parameter int BLANK  = 16,
  localparam int AW    = $clog2(DIGITS)
) (
  input  logic              sysClk,
  input  logic              sysRst_n,
  input  logic              wrValid,
  output logic              wrReady,
  input  logic [AW-1:0]     wrAddr,
  input  logic [DW-1:0]     wrData,
  input  logic              commit,
  input  logic [DIGITS-1:0] digitEn,
  output logic [DW-1:0]     boundedData,
  output logic [DIGITS-1:0] COM,
  output logic              frameStart
);

  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t            state_reg;
  logic [AW-1:0]     idx_reg;
  logic [CW-1:0]     cnt_reg;
  logic [DIGITS-1:0] com_reg;
  logic [DW-1:0]     data_reg;
  logic              frame_start_reg;
  logic              pending_reg;
  logic [DW-1:0]     shadow_reg [DIGITS];
  logic [DW-1:0]     active_reg [DIGITS];

  logic              wr_accept;
  logic              frame_boundary;
  logic [DIGITS-1:0] wr_hit;
  logic [DIGITS-1:0] idx_onehot;

  assign wr_accept      = wrValid && !pending_reg;
  assign frame_boundary = (state_reg == ST_DRIVE) && (cnt_reg == CW'(DWELL - 1)) &&
                          (idx_reg == AW'(DIGITS - 1));
  assign idx_onehot     = {{(DIGITS-1){1'b0}}, 1'b1} << idx_reg;

  // Out-of-range addresses match no entry, so the handshake completes but data is dropped.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hit
      assign wr_hit[gi] = wr_accept && (wrAddr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_reg       <= ST_BLANK;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      com_reg         <= '0;
      data_reg        <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      case (state_reg)
        ST_BLANK: begin
          data_reg <= active_reg[idx_reg];
          if (cnt_reg == CW'(BLANK - 1)) begin
            state_reg <= ST_DRIVE;
            cnt_reg   <= '0;
            com_reg   <= digitEn[idx_reg] ? idx_onehot : '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_reg == CW'(DWELL - 1)) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
            com_reg   <= '0;
            if (idx_reg == AW'(DIGITS - 1)) begin
              idx_reg         <= '0;
              frame_start_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + AW'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= ST_BLANK;
      endcase
    end
  end

  // Writes are blocked while a commit is pending, so the copy always sees a stable shadow.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      pending_reg <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      if (frame_boundary && pending_reg) begin
        pending_reg <= 1'b0;
      end else if (commit && !pending_reg) begin
        pending_reg <= 1'b1;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_hit[i]) begin
          shadow_reg[i] <= wrData;
        end
        if (frame_boundary && pending_reg) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
    end
  end

  assign wrReady     = !pending_reg;
  assign COM         = com_reg;
  assign boundedData = data_reg;
  assign frameStart  = frame_start_reg;

endmodule
